// File: rtl/sm_to_2comp_serial.sv
// Bit-serial sign-magnitude to two's-complement converter.
// Produces an (N+1)-bit result one bit per clock using the "copy through first 1, then invert" rule.
module sm_to_2comp_serial #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         RESET,
  input  logic         S,
  input  logic         sign,
  input  logic [N-1:0] mag,
  output logic         busy,
  output logic         done,
  output logic [N:0]   result
);

  // state | meaning
  // IDLE  | waiting for S; operands captured on the edge that leaves IDLE
  // SHIFT | one operand bit converted per cycle, LSB first, N+1 cycles
  // DONE  | result valid and newly loaded, done pulse, back to IDLE
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int CW = $clog2(N + 1);

  state_t          state;
  state_t          state_nxt;
  logic            sign_r;
  logic [N:0]      op_r;
  logic [N:0]      sh;
  logic [CW-1:0]   cnt;
  logic            found_one;
  logic            bit_in;
  logic            bit_out;
  logic            last;

  assign bit_in  = op_r[cnt];
  assign bit_out = (sign_r && found_one) ? ~bit_in : bit_in;
  assign last    = (cnt == CW'(N));

  always_ff @(posedge clk) begin
    if (!RESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (S) state_nxt = SHIFT;
      SHIFT:   if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      SHIFT: busy = 1'b1;
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!RESET) begin
      sign_r    <= 1'b0;
      op_r      <= '0;
      sh        <= '0;
      cnt       <= '0;
      found_one <= 1'b0;
      result    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (S) begin
            sign_r    <= sign;
            op_r      <= {1'b0, mag};
            sh        <= '0;
            cnt       <= '0;
            found_one <= 1'b0;
          end
        end
        SHIFT: begin
          sh  <= {bit_out, sh[N:1]};
          cnt <= cnt + CW'(1);
          if (sign_r) found_one <= found_one | bit_in;
          // Result is loaded only once, so it never exposes a partial word.
          if (last) result <= {bit_out, sh[N:1]};
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sm_to_2comp_serial.sv
// Self-checking bench for sm_to_2comp_serial (N=4) against an arithmetic reference model.
module tb_sm_to_2comp_serial;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         RESET;
  logic         S;
  logic         sign;
  logic [N-1:0] mag;
  logic         busy;
  logic         done;
  logic [N:0]   result;

  int total = 0;
  int bad   = 0;

  sm_to_2comp_serial #(.N(N)) dut (
    .clk    (clk),
    .RESET  (RESET),
    .S      (S),
    .sign   (sign),
    .mag    (mag),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  function automatic logic [N:0] ref_conv(input logic s, input logic [N-1:0] m);
    int v;
    v = s ? -int'(m) : int'(m);
    return v[N:0];
  endfunction

  // Starts one conversion from IDLE and waits for done; returns observations only.
  task automatic run_conv(input logic s, input logic [N-1:0] m,
                          output int lat, output int busy_cnt, output logic [N:0] res);
    @(negedge clk);
    S = 1'b1; sign = s; mag = m;
    @(posedge clk);
    @(negedge clk);
    S = 1'b0; sign = 1'($urandom); mag = N'($urandom);
    lat = 1;
    busy_cnt = 0;
    while (1) begin
      if (busy) busy_cnt++;
      if (done || lat >= 30) break;
      @(negedge clk);
      lat++;
    end
    res = result;
  endtask

  task automatic test_reset();
    RESET = 1'b0; S = 1'b0; sign = 1'b0; mag = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++;
    if (result !== '0) begin bad++; $display("FAIL reset_result got=%b want=00000", result); end
    RESET = 1'b1;
  endtask

  task automatic test_directed();
    int lat, bc;
    logic [N:0] res;
    logic s_tab [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [N-1:0] m_tab [5] = '{4'b0101, 4'b0101, 4'b1111, 4'b0000, 4'b0000};
    logic [N:0] e_tab [5] = '{5'b00101, 5'b11011, 5'b10001, 5'b00000, 5'b00000};
    for (int i = 0; i < 5; i++) begin
      run_conv(s_tab[i], m_tab[i], lat, bc, res);
      total++;
      if (res !== e_tab[i]) begin
        bad++; $display("FAIL directed_result[%0d] got=%b want=%b", i, res, e_tab[i]);
      end
      total++;
      if (lat != N + 2) begin bad++; $display("FAIL directed_latency[%0d] got=%0d want=%0d", i, lat, N + 2); end
      total++;
      if (bc != N + 2) begin bad++; $display("FAIL directed_busy_cycles[%0d] got=%0d want=%0d", i, bc, N + 2); end
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        bad++; $display("FAIL directed_idle_after[%0d] got busy=%b done=%b want 0 0", i, busy, done);
      end
      total++;
      if (result !== e_tab[i]) begin
        bad++; $display("FAIL directed_result_held[%0d] got=%b want=%b", i, result, e_tab[i]);
      end
    end
  endtask

  task automatic test_ignore_busy();
    int w;
    @(negedge clk);
    S = 1'b1; sign = 1'b1; mag = 4'b0011;
    @(posedge clk);
    @(negedge clk);
    S = 1'b0;
    @(negedge clk);
    S = 1'b1; sign = 1'b0; mag = 4'b1000;
    w = 2;
    while (!done && w < 30) begin
      @(negedge clk);
      w++;
    end
    S = 1'b0;
    total++;
    if (done !== 1'b1 || w != N + 2) begin
      bad++; $display("FAIL ignore_done got done=%b at=%0d want done=1 at=%0d", done, w, N + 2);
    end
    total++;
    if (result !== 5'b11101) begin bad++; $display("FAIL ignore_result got=%b want=11101", result); end
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL ignore_no_restart got busy=%b want=0", busy); end
  endtask

  task automatic test_mid_reset();
    int lat, bc;
    logic [N:0] res;
    @(negedge clk);
    S = 1'b1; sign = 1'b0; mag = 4'b1001;
    @(posedge clk);
    @(negedge clk);
    S = 1'b0;
    @(negedge clk);
    @(negedge clk);
    RESET = 1'b0;
    @(posedge clk);
    @(negedge clk);
    RESET = 1'b1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL midreset_flags got busy=%b done=%b want 0 0", busy, done);
    end
    total++;
    if (result !== '0) begin bad++; $display("FAIL midreset_result got=%b want=00000", result); end
    repeat (8) begin
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        bad++; $display("FAIL midreset_discarded got busy=%b done=%b want 0 0", busy, done);
      end
    end
    run_conv(1'b1, 4'b0110, lat, bc, res);
    total++;
    if (res !== 5'b11010 || lat != N + 2) begin
      bad++; $display("FAIL midreset_fresh got=%b lat=%0d want=11010 lat=%0d", res, lat, N + 2);
    end
  endtask

  task automatic test_back_to_back();
    int w;
    logic [4:0] code;
    logic [N:0] exp;
    @(negedge clk);
    S = 1'b1; sign = 1'b0; mag = '0;
    for (int i = 0; i < 32; i++) begin
      w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (!done && w < 30);
      code = 5'(i);
      exp = ref_conv(code[4], code[3:0]);
      total++;
      if (done !== 1'b1 || w != ((i == 0) ? N + 2 : N + 3)) begin
        bad++; $display("FAIL b2b_period[%0d] got done=%b gap=%0d want gap=%0d", i, done, w, (i == 0) ? N + 2 : N + 3);
      end
      total++;
      if (result !== exp) begin bad++; $display("FAIL b2b_result[%0d] got=%b want=%b", i, result, exp); end
      if (i < 31) begin
        code = 5'(i + 1);
        sign = code[4]; mag = code[3:0];
      end else begin
        S = 1'b0;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_random();
    int lat, bc;
    logic [N:0] res, exp;
    logic s;
    logic [N-1:0] m;
    for (int i = 0; i < 24; i++) begin
      s = 1'($urandom);
      m = N'($urandom_range(0, 15));
      exp = ref_conv(s, m);
      run_conv(s, m, lat, bc, res);
      total++;
      if (res !== exp || lat != N + 2) begin
        bad++; $display("FAIL random[%0d] sign=%b mag=%b got=%b lat=%0d want=%b lat=%0d", i, s, m, res, lat, exp, N + 2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_busy();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
